// File: rtl/mp3_frame_sequencer.sv
// MPEG-1 Layer III frame sequencer: hunts frame sync, replays the header into the parser,
// then splits the frame body into CRC (dropped), side-info and main-data byte streams.
module mp3_frame_sequencer #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned HDR_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  axiid,
    input  logic        axiiv,
    output logic        axiir,
    output logic [7:0]  hdr_axiod,
    output logic        hdr_axiov,
    input  logic        hdr_axiiv,
    input  logic [10:0] hdr_frame_size,
    input  logic        hdr_prot,
    input  logic [1:0]  hdr_mode,
    output logic [7:0]  side_axiod,
    output logic        side_axiov,
    output logic [7:0]  main_axiod,
    output logic        main_axiov,
    output logic        frame_start,
    output logic        frame_done,
    output logic        bad_frame,
    output logic        sync_lost,
    output logic        locked
);

    localparam int unsigned TW = $clog2(HDR_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StHunt, StSync2, StHdr34, StEmit, StWait, StCrc, StSide, StMain, StChk1, StChk2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0][7:0] hdr_q, hdr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [10:0]     rem_q, rem_d;
    logic [5:0]      side_cnt_q, side_cnt_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;

    logic       axiir_d, hdr_axiov_d, side_axiov_d, main_axiov_d;
    logic [7:0] hdr_axiod_d, side_axiod_d, main_axiod_d;
    logic       frame_start_d, frame_done_d, bad_frame_d, sync_lost_d, locked_d;
    logic       acc, is_ff, sync2_ok;

    assign acc      = axiiv && axiir;
    assign is_ff    = (axiid == 8'hFF);
    assign sync2_ok = (axiid[7:4] == 4'hF) && (axiid[3:1] == 3'b101);

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        rem_d         = rem_q;
        side_cnt_d    = side_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked;
        hdr_axiod_d   = 8'h00;
        hdr_axiov_d   = 1'b0;
        side_axiod_d  = 8'h00;
        side_axiov_d  = 1'b0;
        main_axiod_d  = 8'h00;
        main_axiov_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        bad_frame_d   = 1'b0;
        sync_lost_d   = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (acc && is_ff) begin
                    hdr_d[0] = axiid;
                    state_d  = StSync2;
                end
            end
            StSync2: begin
                if (acc) begin
                    if (sync2_ok) begin
                        hdr_d[1] = axiid;
                        cnt_d    = 2'd0;
                        state_d  = StHdr34;
                    end else if (is_ff) begin
                        hdr_d[0] = axiid;
                    end else begin
                        state_d = StHunt;
                    end
                end
            end
            StHdr34: begin
                if (acc) begin
                    hdr_d[{1'b1, cnt_q[0]}] = axiid;
                    cnt_d = 2'd1;
                    // Byte 0 goes out with the last capture so the burst has no gap.
                    if (cnt_q[0]) begin
                        hdr_axiod_d = hdr_q[0];
                        hdr_axiov_d = 1'b1;
                        state_d     = StEmit;
                    end
                end
            end
            StEmit: begin
                hdr_axiod_d = hdr_q[cnt_q];
                hdr_axiov_d = 1'b1;
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    tmr_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (hdr_axiiv) begin
                    if (hdr_frame_size == 11'd0) begin
                        bad_frame_d = 1'b1;
                        lock_cnt_d  = 8'd0;
                        locked_d    = 1'b0;
                        state_d     = StHunt;
                    end else begin
                        frame_start_d = 1'b1;
                        rem_d         = hdr_frame_size - 11'd4;
                        side_cnt_d    = (hdr_mode == 2'b11) ? 6'd17 : 6'd32;
                        cnt_d         = 2'd0;
                        state_d       = hdr_prot ? StSide : StCrc;
                    end
                end else if (tmr_q == TW'(HDR_TIMEOUT)) begin
                    bad_frame_d = 1'b1;
                    state_d     = StHunt;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCrc: begin
                if (acc) begin
                    rem_d = rem_q - 11'd1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q[0]) state_d = StSide;
                end
            end
            StSide: begin
                if (acc) begin
                    side_axiod_d = axiid;
                    side_axiov_d = 1'b1;
                    rem_d        = rem_q - 11'd1;
                    side_cnt_d   = side_cnt_q - 6'd1;
                    if (side_cnt_q == 6'd1) state_d = StMain;
                end
            end
            StMain: begin
                if (acc) begin
                    main_axiod_d = axiid;
                    main_axiov_d = 1'b1;
                    rem_d        = rem_q - 11'd1;
                    if (rem_q == 11'd1) begin
                        frame_done_d = 1'b1;
                        state_d      = StChk1;
                    end
                end
            end
            StChk1, StChk2: begin
                if (acc) begin
                    if (state_q == StChk1 && is_ff) begin
                        hdr_d[0] = axiid;
                        state_d  = StChk2;
                    end else if (state_q == StChk2 && sync2_ok) begin
                        hdr_d[1] = axiid;
                        cnt_d    = 2'd0;
                        state_d  = StHdr34;
                        if (lock_cnt_q < 8'(LOCK_FRAMES)) lock_cnt_d = lock_cnt_q + 8'd1;
                        locked_d = (lock_cnt_d >= 8'(LOCK_FRAMES));
                    end else begin
                        sync_lost_d = locked;
                        lock_cnt_d  = 8'd0;
                        locked_d    = 1'b0;
                        // An 0xFF that fails the second-byte test may itself start a sync.
                        if (state_q == StChk2 && is_ff) begin
                            hdr_d[0] = axiid;
                            state_d  = StSync2;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        axiir_d = !(state_d inside {StEmit, StWait});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            hdr_q       <= '0;
            cnt_q       <= 2'd0;
            tmr_q       <= '0;
            rem_q       <= 11'd0;
            side_cnt_q  <= 6'd0;
            lock_cnt_q  <= 8'd0;
            axiir       <= 1'b1;
            hdr_axiod   <= 8'h00;
            hdr_axiov   <= 1'b0;
            side_axiod  <= 8'h00;
            side_axiov  <= 1'b0;
            main_axiod  <= 8'h00;
            main_axiov  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            bad_frame   <= 1'b0;
            sync_lost   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            rem_q       <= rem_d;
            side_cnt_q  <= side_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            axiir       <= axiir_d;
            hdr_axiod   <= hdr_axiod_d;
            hdr_axiov   <= hdr_axiov_d;
            side_axiod  <= side_axiod_d;
            side_axiov  <= side_axiov_d;
            main_axiod  <= main_axiod_d;
            main_axiov  <= main_axiov_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
            bad_frame   <= bad_frame_d;
            sync_lost   <= sync_lost_d;
            locked      <= locked_d;
        end
    end

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// Directed bench for mp3_frame_sequencer: a small header-parser model answers each replayed
// header, and routed side/main bytes are compared against the bytes that were sent.
module tb_mp3_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  axiid;
    logic        axiiv;
    logic        axiir;
    logic [7:0]  hdr_axiod;
    logic        hdr_axiov;
    logic        hdr_axiiv = 1'b0;
    logic [10:0] hdr_frame_size;
    logic        hdr_prot;
    logic [1:0]  hdr_mode;
    logic [7:0]  side_axiod;
    logic        side_axiov;
    logic [7:0]  main_axiod;
    logic        main_axiov;
    logic        frame_start, frame_done, bad_frame, sync_lost, locked;

    always #5 clk = ~clk;

    mp3_frame_sequencer #(.LOCK_FRAMES(2), .HDR_TIMEOUT(3)) dut (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv), .axiir(axiir),
        .hdr_axiod(hdr_axiod), .hdr_axiov(hdr_axiov), .hdr_axiiv(hdr_axiiv),
        .hdr_frame_size(hdr_frame_size), .hdr_prot(hdr_prot), .hdr_mode(hdr_mode),
        .side_axiod(side_axiod), .side_axiov(side_axiov),
        .main_axiod(main_axiod), .main_axiov(main_axiov),
        .frame_start(frame_start), .frame_done(frame_done), .bad_frame(bad_frame),
        .sync_lost(sync_lost), .locked(locked)
    );

    int npass = 0, nfail = 0, ntot = 0;

    // Parser model configuration (written only by the stimulus process)
    logic [10:0] p_size = 11'd417;
    logic        p_prot = 1'b1;
    logic [1:0]  p_mode = 2'b00;
    bit          p_silent = 1'b0;
    assign hdr_frame_size = p_size;
    assign hdr_prot       = p_prot;
    assign hdr_mode       = p_mode;

    // Observations (written only by the monitor process)
    logic [7:0]  side_seen[$];
    logic [7:0]  main_seen[$];
    logic [31:0] hdr_word = 32'h0;
    int hdr_cnt = 0, cyc = 0, last_hdr_cyc = 0, bad_cyc = 0, done_main = 0;
    int n_start = 0, n_done = 0, n_bad = 0, n_lost = 0, n_stall = 0;
    bit pend = 1'b0;

    // Snapshot bases and expected body streams
    int b_side, b_main, b_start, b_done, b_bad, b_lost, b_stall;
    logic [7:0] exp_side[$];
    logic [7:0] exp_main[$];

    always @(posedge clk) begin
        #2;
        cyc++;
        hdr_axiiv = pend;
        pend = 1'b0;
        if (hdr_axiov) begin
            hdr_word = {hdr_word[23:0], hdr_axiod};
            last_hdr_cyc = cyc;
            hdr_cnt++;
            if (hdr_cnt == 4) begin
                hdr_cnt = 0;
                pend = !p_silent;
            end
        end
        if (side_axiov) side_seen.push_back(side_axiod);
        if (main_axiov) main_seen.push_back(main_axiod);
        if (frame_start) n_start++;
        if (frame_done) begin
            n_done++;
            done_main = main_seen.size();
        end
        if (bad_frame) begin
            n_bad++;
            bad_cyc = cyc;
        end
        if (sync_lost) n_lost++;
        if (!axiir) n_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic snapshot();
        b_side  = side_seen.size();
        b_main  = main_seen.size();
        b_start = n_start;
        b_done  = n_done;
        b_bad   = n_bad;
        b_lost  = n_lost;
        b_stall = n_stall;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        axiid = b;
        axiiv = 1'b1;
        t = 0;
        while (!axiir && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) chk("accept_timeout", t, 0);
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] hw, input int size, input bit prot,
                             input logic [1:0] mode, input int nsend, input bit gaps,
                             input int seed);
        int crc, sl;
        logic [7:0] b;
        snapshot();
        p_size = size[10:0];
        p_prot = prot;
        p_mode = mode;
        exp_side.delete();
        exp_main.delete();
        crc = prot ? 0 : 2;
        sl  = (mode == 2'b11) ? 17 : 32;
        for (int i = 0; i < 4; i++) send(hw[31-8*i -: 8], gaps);
        for (int k = 0; k < size - 4 && k < nsend; k++) begin
            b = 8'(seed + k * 13);
            if (k >= crc && k < crc + sl) exp_side.push_back(b);
            else if (k >= crc + sl) exp_main.push_back(b);
            send(b, gaps);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] hw, input int nside,
                               input int nmain);
        int ms, mm;
        repeat (3) @(negedge clk);
        chk({tag, "_hdr_burst"}, hdr_word, hw);
        chk({tag, "_frame_start"}, n_start - b_start, 1);
        chk({tag, "_frame_done"}, n_done - b_done, 1);
        chk({tag, "_no_bad"}, n_bad - b_bad, 0);
        chk({tag, "_side_count"}, side_seen.size() - b_side, nside);
        chk({tag, "_main_count"}, main_seen.size() - b_main, nmain);
        chk({tag, "_done_on_last"}, done_main - b_main, nmain);
        chk({tag, "_hdr_stall"}, n_stall - b_stall, 5);
        ms = 0;
        mm = 0;
        for (int i = 0; i < exp_side.size(); i++)
            if (b_side + i >= side_seen.size() || side_seen[b_side + i] !== exp_side[i]) ms++;
        for (int i = 0; i < exp_main.size(); i++)
            if (b_main + i >= main_seen.size() || main_seen[b_main + i] !== exp_main[i]) mm++;
        chk({tag, "_side_data_errs"}, ms, 0);
        chk({tag, "_main_data_errs"}, mm, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, bd0;
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_axiir", axiir, 1);
        chk("rst_hdr_axiov", hdr_axiov, 0);
        chk("rst_side_axiov", side_axiov, 0);
        chk("rst_main_axiov", main_axiov, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_start", frame_start, 0);
        rst = 1'b0;
        @(negedge clk);

        // Stereo, no CRC
        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 9999, 1'b0, 1);
        check_frame("a", 32'hFFFB9000, 32, 381);
        chk("a_locked", locked, 0);

        // Mono with CRC, at the expected boundary
        run_frame(32'hFFFA90C0, 417, 1'b0, 2'b11, 9999, 1'b0, 5);
        check_frame("b", 32'hFFFA90C0, 17, 394);

        // Garbage before a padded frame; resync on the second FF FF FB
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        run_frame(32'hFFFB9200, 418, 1'b1, 2'b00, 9999, 1'b0, 7);
        check_frame("c", 32'hFFFB9200, 32, 382);
        chk("c_no_sync_lost", n_lost, 0);
        chk("c_locked", locked, 0);

        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 9999, 1'b0, 11);
        check_frame("d", 32'hFFFB9000, 32, 381);
        chk("d_locked", locked, 0);

        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 9999, 1'b0, 13);
        check_frame("e", 32'hFFFB9000, 32, 381);
        chk("e_locked", locked, 1);

        // Corrupt first byte of the next frame while locked
        snapshot();
        send(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("f_sync_lost", n_lost - b_lost, 1);
        chk("f_locked", locked, 0);

        // Parser reports size 0
        run_frame(32'hFFFB0000, 0, 1'b1, 2'b00, 0, 1'b0, 0);
        repeat (8) @(negedge clk);
        chk("g_bad_frame", n_bad - b_bad, 1);
        chk("g_no_start", n_start - b_start, 0);
        chk("g_hdr_burst", hdr_word, 32'hFFFB0000);
        chk("g_axiir", axiir, 1);

        // Parser never answers
        p_silent = 1'b1;
        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("h_bad_frame", n_bad - b_bad, 1);
        chk("h_bad_latency", bad_cyc - last_hdr_cyc, 4);
        chk("h_no_start", n_start - b_start, 0);
        chk("h_axiir", axiir, 1);
        p_silent = 1'b0;

        // Random valid gaps everywhere
        run_frame(32'hFFFA90C0, 417, 1'b0, 2'b11, 9999, 1'b1, 9);
        check_frame("i", 32'hFFFA90C0, 17, 394);

        // Reset in the middle of main data
        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 100, 1'b0, 3);
        chk("j_main_active", main_axiov, 1);
        d0  = n_done;
        bd0 = n_bad;
        rst = 1'b1;
        #1;
        chk("j_rst_axiir", axiir, 1);
        chk("j_rst_main_axiov", main_axiov, 0);
        chk("j_rst_side_axiov", side_axiov, 0);
        chk("j_rst_hdr_axiov", hdr_axiov, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("j_no_done", n_done - d0, 0);
        chk("j_no_bad", n_bad - bd0, 0);

        run_frame(32'hFFFB9000, 417, 1'b1, 2'b00, 9999, 1'b0, 21);
        check_frame("k", 32'hFFFB9000, 32, 381);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
